// File: rtl/gate_truth_sweep.sv
// gate_truth_sweep: drives the four-gate lab block (f0=AND, f1=OR, f2=XOR,
// f3=NAND) through the full 2-input truth table. After SETTLE+1 cycles on each
// vector it samples the f lines and compares them with the expected results.
// Any gate that mismatches is recorded in a sticky fail mask. A pass flag and a
// one-cycle done pulse are reported at the end of each sweep.
module gate_truth_sweep #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] a,
    output logic [3:0] b,
    input  logic [3:0] f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
);

    // The settle counter only has to reach SETTLE-1.
    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Expected gate outputs for vector k, where x=k[1] and y=k[0].
    function automatic logic [3:0] expected_f(input logic [1:0] k);
        return {~(k[1] & k[0]), k[1] ^ k[0], k[1] | k[0], k[1] & k[0]};
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    vec_q, vec_d;
    logic [3:0]    mask_q, mask_d;
    logic          pass_q, pass_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state logic. Outputs are derived from the next state so that they
    // can be registered and still line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = 4'd0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_SAMPLE: begin
                // Only the f value present on the edge leaving SAMPLE counts.
                // f during DRIVE may glitch freely.
                mask_d = mask_q | (f ^ expected_f(vec_q));
                if (vec_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                pass_d  = (mask_q == 4'd0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        if (busy_d) begin
            a_d = {4{vec_d[1]}};
            b_d = {4{vec_d[0]}};
        end else begin
            a_d = 4'd0;
            b_d = 4'd0;
        end
    end

    // Register the state and all outputs. Reset aborts a sweep at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            vec_q   <= 2'd0;
            mask_q  <= 4'd0;
            pass_q  <= 1'b0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign vec_idx   = vec_q;

endmodule

// File: tb/tb_gate_truth_sweep.sv
// Bench for gate_truth_sweep. It builds a behavioural gate block with
// per-vector corruption and DRIVE-phase glitches. The expected fail mask is
// the OR of the corruption that is applied while each vector is sampled.
// Expected timing comes from the sweep schedule: SETTLE+1 cycles per vector.
module tb_gate_truth_sweep;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start2, start1;
    logic [3:0] a2, b2, f2, a1, b1, f1;
    logic       busy2, done2, pass2, busy1, done1, pass1;
    logic [3:0] mask2, mask1;
    logic [1:0] vec2, vec1;

    logic [3:0] corr [4];
    logic [3:0] noise2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_truth_sweep #(.SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .f(f2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2), .vec_idx(vec2)
    );

    gate_truth_sweep #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .f(f1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1), .vec_idx(vec1)
    );

    function automatic logic [3:0] gates(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        r[0] = x[0] & y[0];
        r[1] = x[1] | y[1];
        r[2] = x[2] ^ y[2];
        r[3] = ~(x[3] & y[3]);
        return r;
    endfunction

    // Gate block model: the ideal gates, with the fault for the current vector
    // and any DRIVE-phase noise XORed onto the outputs.
    always_comb begin
        f2 = gates(a2, b2) ^ corr[{a2[0], b2[0]}] ^ noise2;
        f1 = gates(a1, b1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full sweep on the SETTLE=2 instance, checked cycle by cycle.
    task automatic sweep2(input logic glitch, input logic repulse,
                          input logic [3:0] exp_mask, input logic exp_pass);
        int k;
        int p;
        logic [1:0] kv;
        @(negedge clk);
        start2 = 1'b1;
        noise2 = 4'd0;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start2 = repulse && (c == 8 || c == 13);
            if (c <= 12) begin
                k  = (c - 1) / 3;
                p  = (c - 1) % 3;
                kv = 2'(k);
                chk("busy_sweep", {7'd0, busy2}, 8'd1);
                chk("done_early", {7'd0, done2}, 8'd0);
                chk("vec_idx", {6'd0, vec2}, {6'd0, kv});
                chk("a_vec", {4'd0, a2}, {4'd0, {4{kv[1]}}});
                chk("b_vec", {4'd0, b2}, {4'd0, {4{kv[0]}}});
                noise2 = (glitch && p < 2) ? 4'($urandom) : 4'd0;
            end else begin
                noise2 = 4'd0;
                chk("busy_end", {7'd0, busy2}, 8'd0);
                chk("done_pulse", {7'd0, done2}, {7'd0, (c == 13)});
                chk("a_idle", {4'd0, a2}, 8'd0);
                chk("b_idle", {4'd0, b2}, 8'd0);
                if (c >= 14) begin
                    chk("fail_mask", {4'd0, mask2}, {4'd0, exp_mask});
                    chk("pass", {7'd0, pass2}, {7'd0, exp_pass});
                end
            end
        end
    endtask

    typedef struct {
        logic [3:0] c0, c1, c2, c3;
        logic       glitch;
        logic       repulse;
        logic [3:0] exp_mask;
        logic       exp_pass;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [3:0] em;
        int         done_cnt;

        // ideal gates
        tbl[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b1};
        // f2 stuck at 0: XOR is 1 on vectors 1 and 2
        tbl[1] = '{4'h0, 4'h4, 4'h4, 4'h0, 1'b0, 1'b0, 4'b0100, 1'b0};
        // f3 is AND instead of NAND: wrong on all vectors
        tbl[2] = '{4'h8, 4'h8, 4'h8, 4'h8, 1'b0, 1'b0, 4'b1000, 1'b0};
        // start re-pulsed during vector 2 and during DONE
        tbl[3] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b1};
        // glitches during DRIVE only must be ignored
        tbl[4] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1};
        // f0 wrong only on the last vector, with glitches
        tbl[5] = '{4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 4'b0001, 1'b0};

        rst_n  = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        noise2 = 4'd0;
        for (int i = 0; i < 4; i++) corr[i] = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a", {4'd0, a2}, 8'd0);
        chk("rst_b", {4'd0, b2}, 8'd0);
        chk("rst_busy", {7'd0, busy2}, 8'd0);
        chk("rst_done", {7'd0, done2}, 8'd0);
        chk("rst_pass", {7'd0, pass2}, 8'd0);
        chk("rst_mask", {4'd0, mask2}, 8'd0);
        chk("rst_vec", {6'd0, vec2}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            corr[0] = tbl[t].c0;
            corr[1] = tbl[t].c1;
            corr[2] = tbl[t].c2;
            corr[3] = tbl[t].c3;
            sweep2(tbl[t].glitch, tbl[t].repulse, tbl[t].exp_mask, tbl[t].exp_pass);
        end

        // randomized fault patterns
        for (int r = 0; r < 10; r++) begin
            em = 4'd0;
            for (int i = 0; i < 4; i++) begin
                corr[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
                em = em | corr[i];
            end
            sweep2(1'($urandom), 1'b0, em, (em == 4'd0));
        end

        // Reset during vector 1 SAMPLE aborts the sweep with no clock edge.
        corr[0] = 4'b0101;
        corr[1] = 4'd0;
        corr[2] = 4'd0;
        corr[3] = 4'd0;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start2 = 1'b0;
        end
        chk("pre_rst_vec", {6'd0, vec2}, 8'd1);
        chk("pre_rst_mask", {4'd0, mask2}, 8'b0101);
        #1 rst_n = 1'b0;
        #1;
        chk("async_a", {4'd0, a2}, 8'd0);
        chk("async_b", {4'd0, b2}, 8'd0);
        chk("async_busy", {7'd0, busy2}, 8'd0);
        chk("async_mask", {4'd0, mask2}, 8'd0);
        chk("async_vec", {6'd0, vec2}, 8'd0);
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done2) done_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done2) done_cnt++;
        end
        chk("no_done_after_abort", 8'(done_cnt), 8'd0);
        corr[0] = 4'd0;
        sweep2(1'b0, 1'b0, 4'd0, 1'b1);

        // SETTLE=1 with start held: done at +9 and +19, one IDLE cycle between.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 20) start1 = 1'b0;
            chk("s1_done", {7'd0, done1}, {7'd0, (c == 9 || c == 19)});
            chk("s1_busy", {7'd0, busy1},
                {7'd0, ((c >= 1 && c <= 8) || (c >= 11 && c <= 18))});
        end
        chk("s1_pass", {7'd0, pass1}, 8'd1);
        chk("s1_mask", {4'd0, mask1}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
